// File: rtl/alu_pkg.sv
// Shared opcode and FSM definitions for the EX-stage ALU and its iterative multiplier.
package alu_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SUB  = 4'b0100;
    localparam logic [3:0] ALU_NOR  = 4'b0101;
    localparam logic [3:0] ALU_SLTU = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_MUL  = 4'b1000;
    localparam logic [3:0] ALU_SRL  = 4'b1010;
    localparam logic [3:0] ALU_SRA  = 4'b1011;
    localparam logic [3:0] ALU_SLL  = 4'b1100;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Unsigned shift-add multiplier: one multiplier bit per cycle, WIDTH steps after start.
// The step counter is a down-counter; done flags the edge that performs the final step.
module alu_mul_iter #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   prod
);
    localparam int CW = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   sum;

    assign sum  = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
    assign done = busy && (cnt == CW'(1));
    assign prod = {hi, lo};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand <= '0;
            hi    <= '0;
            lo    <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
        end else if (flush) begin
            cnt   <= '0;
            busy  <= 1'b0;
        end else if (start) begin
            mcand <= a;
            hi    <= '0;
            lo    <= b;
            cnt   <= CW'(WIDTH);
            busy  <= 1'b1;
        end else if (busy) begin
            // carry out of the add lands in hi[WIDTH-1] as everything shifts right
            {hi, lo} <= {sum, lo[WIDTH-1:1]};
            cnt      <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// Registered EX-stage ALU with valid/ready handshake, iterative MUL and branch flush.
//   state  | meaning
//   S_IDLE | accepting ops, single-cycle results registered on accept
//   S_MUL  | multiplier running, in_ready low until the product is presented
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       alu_ctrl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             overflow
);
    localparam int SHW = $clog2(WIDTH);

    state_t state_q, state_d;

    logic                 accept;
    logic                 is_mul;
    logic                 mul_busy;
    logic                 mul_done;
    logic [2*WIDTH-1:0]   mul_prod;

    logic [SHW-1:0]          shamt;
    logic [WIDTH-1:0]        sum;
    logic [WIDTH-1:0]        diff;
    logic signed [WIDTH-1:0] sra_res;
    logic [WIDTH-1:0]        op_res;
    logic                    op_ovf;

    logic [WIDTH-1:0] res_q;
    logic             zero_q;
    logic             ovf_q;
    logic             mul_sel;

    assign is_mul   = (alu_ctrl == ALU_MUL);
    assign in_ready = (state_q == S_IDLE) & ~mul_busy & (~out_valid | out_ready) & ~flush;
    assign accept   = in_valid & in_ready;

    assign shamt   = b[SHW-1:0];
    assign sum     = a + b;
    assign diff    = a - b;
    assign sra_res = $signed(a) >>> shamt;

    always_comb begin
        op_res = '0;
        op_ovf = 1'b0;
        case (alu_ctrl)
            ALU_AND:  op_res = a & b;
            ALU_OR:   op_res = a | b;
            ALU_XOR:  op_res = a ^ b;
            ALU_NOR:  op_res = ~(a | b);
            ALU_ADD: begin
                op_res = sum;
                op_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_SUB: begin
                op_res = diff;
                op_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_SLT:  op_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU: op_res = {{(WIDTH-1){1'b0}}, (a < b)};
            ALU_SLL:  op_res = a << shamt;
            ALU_SRL:  op_res = a >> shamt;
            ALU_SRA:  op_res = sra_res;
            default: begin
                op_res = '0;
                op_ovf = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (accept && is_mul) state_d = S_MUL;
                S_MUL:   if (mul_done)         state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            res_q     <= '0;
            zero_q    <= 1'b0;
            ovf_q     <= 1'b0;
            mul_sel   <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            if (is_mul) begin
                out_valid <= 1'b0;
                ovf_q     <= 1'b0;
                mul_sel   <= 1'b1;
            end else begin
                out_valid <= 1'b1;
                res_q     <= op_res;
                zero_q    <= (op_res == '0);
                ovf_q     <= op_ovf;
                mul_sel   <= 1'b0;
            end
        end else if (state_q == S_MUL && mul_done) begin
            out_valid <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // MUL results are read straight from the multiplier's product register,
    // which holds until the next MUL is accepted.
    assign result    = mul_sel ? mul_prod[WIDTH-1:0] : res_q;
    assign result_hi = mul_sel ? mul_prod[2*WIDTH-1:WIDTH] : '0;
    assign zero      = mul_sel ? (mul_prod[WIDTH-1:0] == '0) : zero_q;
    assign overflow  = ovf_q;

    alu_mul_iter #(
        .WIDTH(WIDTH)
    ) u_mul (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .start (accept && is_mul),
        .a     (a),
        .b     (b),
        .busy  (mul_busy),
        .done  (mul_done),
        .prod  (mul_prod)
    );

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: directed corner cases plus randomized ops checked against an arithmetic model.
module tb_alu_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  alu_ctrl;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [31:0] result_hi;
    logic        zero;
    logic        overflow;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    bit rand_rdy = 1'b0;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] r;
        logic [31:0] h;
        logic        z;
        logic        o;
        int          acc;
        int          lat;
    } exp_t;

    exp_t q[$];

    alu_pipe #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .alu_ctrl  (alu_ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .result_hi (result_hi),
        .zero      (zero),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (rand_rdy) begin
            #1 out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    function automatic exp_t model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
        exp_t        e;
        longint      s;
        logic [63:0] p;
        int          n;
        e.op = op; e.r = 32'h0; e.h = 32'h0; e.o = 1'b0; e.acc = 0; e.lat = -1;
        n = int'(y[4:0]);
        case (op)
            4'b0000: e.r = x & y;
            4'b0001: e.r = x | y;
            4'b0011: e.r = x ^ y;
            4'b0101: e.r = ~(x | y);
            4'b0010: begin
                e.r = x + y;
                s = longint'($signed(x)) + longint'($signed(y));
                e.o = (s > 64'sd2147483647) || (s < -(64'sd2147483648));
            end
            4'b0100: begin
                e.r = x - y;
                s = longint'($signed(x)) - longint'($signed(y));
                e.o = (s > 64'sd2147483647) || (s < -(64'sd2147483648));
            end
            4'b0111: e.r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            4'b0110: e.r = (x < y) ? 32'd1 : 32'd0;
            4'b1100: e.r = x << n;
            4'b1010: e.r = x >> n;
            4'b1011: e.r = (x >> n) | (x[31] ? ~(32'hFFFF_FFFF >> n) : 32'h0);
            4'b1000: begin
                p = 64'(x) * 64'(y);
                e.r = p[31:0];
                e.h = p[63:32];
            end
            default: e.r = 32'h0;
        endcase
        e.z = (e.r == 32'h0);
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                         input bit push, input int lat, output int waits);
        exp_t e;
        bit   ok;
        in_valid = 1'b1; alu_ctrl = op; a = x; b = y;
        waits = 0; ok = 1'b0;
        while (!ok && waits <= 200) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            else waits++;
        end
        if (!ok) begin
            chk("issue_timeout", 64'(waits), 64'd0);
        end else if (push) begin
            e = model(op, x, y);
            e.acc = cyc + 1;
            e.lat = lat;
            q.push_back(e);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        bit ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (q.size() == 0 && !out_valid) ok = 1'b1;
        end
        if (!ok) chk("drain_timeout", 64'(q.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin : monitor
        exp_t e;
        int   d;
        forever begin
            @(negedge clk);
            if (!rst && !flush && out_valid && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: got result %h with no op pending", result);
                end else begin
                    e = q.pop_front();
                    d = cyc - e.acc;
                    if (result !== e.r || result_hi !== e.h || zero !== e.z || overflow !== e.o ||
                        (e.lat >= 0 && d != e.lat)) begin
                        errors++;
                        $display("FAIL sb op=%h: got r=%h hi=%h z=%b o=%b lat=%0d expected r=%h hi=%h z=%b o=%b lat=%0d",
                                 e.op, result, result_hi, zero, overflow, d, e.r, e.h, e.z, e.o, e.lat);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin : main
        int          w;
        int          n;
        bit          saw;
        logic [3:0]  ops [12];
        logic [3:0]  op;
        ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101,
                4'b0111, 4'b0110, 4'b1100, 4'b1010, 4'b1011, 4'b1000};

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; a = 0; b = 0; alu_ctrl = 0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_outputs", {result, result_hi}, 64'd0);
        chk("rst_flags", {62'd0, zero, overflow}, 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;

        issue(4'b0010, 32'h7FFF_FFFF, 32'h1, 1'b1, 0, w);
        issue(4'b0100, 32'd5, 32'd5, 1'b1, 0, w);
        chk("b2b_ready_sub", 64'(w), 64'd0);
        issue(4'b0111, 32'hFFFF_FFFF, 32'd1, 1'b1, 0, w);
        chk("b2b_ready_slt", 64'(w), 64'd0);
        issue(4'b1011, 32'h8000_0000, 32'h24, 1'b1, 0, w);
        issue(4'b1010, 32'h8000_0000, 32'h24, 1'b1, 0, w);
        issue(4'b1001, 32'h1234_5678, 32'h1, 1'b1, 0, w);
        drain();

        issue(4'b1000, 32'hFFFF_FFFF, 32'd2, 1'b1, 32, w);
        n = 0;
        while (n <= 100) begin
            @(negedge clk);
            if (in_ready) break;
            n++;
        end
        chk("mul_busy_cycles", 64'(n), 64'd32);
        drain();

        out_ready = 1'b0;
        issue(4'b0010, 32'd3, 32'd4, 1'b1, -1, w);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold", {31'd0, out_valid, 31'd0, in_ready, result}, {31'd0, 1'b1, 31'd0, 1'b0, 32'd7});
        end
        @(posedge clk); #1 out_ready = 1'b1;
        drain();

        issue(4'b1000, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0, 0, w);
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        saw = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) saw = 1'b1;
        end
        chk("flush_no_valid", 64'(saw), 64'd0);
        @(posedge clk); #1;
        issue(4'b0010, 32'd1, 32'd1, 1'b1, 0, w);
        drain();

        issue(4'b1000, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0, 0, w);
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_mul_result", {result, result_hi}, 64'd0);
        saw = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) saw = 1'b1;
        end
        chk("rst_no_valid", 64'(saw), 64'd0);
        @(posedge clk); #1;
        issue(4'b0010, 32'd1, 32'd1, 1'b1, 0, w);
        drain();

        rand_rdy = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 12) == 0) op = 4'($urandom);
            else op = ops[$urandom_range(0, 11)];
            issue(op, $urandom, $urandom, 1'b1, -1, w);
        end
        rand_rdy = 1'b0;
        @(posedge clk); #2 out_ready = 1'b1;
        drain();
        chk("queue_empty", 64'(q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
